// File: rtl/aes_text_out_miter_checker.sv
// Miter checker for gold/gate aes_cipher_top text_out streams: per-side skew FIFOs,
// pairwise bitwise compare, sticky verdicts and saturating statistics.
module aes_text_out_miter_checker #(
  parameter int WIDTH        = 128,
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     gold_valid,
  input  logic [WIDTH-1:0]         gold_data,
  input  logic                     gate_valid,
  input  logic [WIDTH-1:0]         gate_data,
  output logic                     busy,
  output logic                     fail,
  output logic                     overflow,
  output logic                     halted,
  output logic [CNT_W-1:0]         compare_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [$clog2(WIDTH)-1:0] first_bad_bit,
  output logic [CNT_W-1:0]         first_bad_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] gold_mem [DEPTH];
  logic [WIDTH-1:0] gate_mem [DEPTH];
  logic [AW:0]      gold_wp, gold_rp, gate_wp, gate_rp;

  logic             gold_empty, gold_full, gate_empty, gate_full;
  logic             active, pop, gold_push, gate_push, gold_drop, gate_drop;
  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic [BW-1:0]    low_bit;

  assign gold_empty = (gold_wp == gold_rp);
  assign gate_empty = (gate_wp == gate_rp);
  assign gold_full  = (gold_wp[AW] != gold_rp[AW]) && (gold_wp[AW-1:0] == gold_rp[AW-1:0]);
  assign gate_full  = (gate_wp[AW] != gate_rp[AW]) && (gate_wp[AW-1:0] == gate_rp[AW-1:0]);
  assign busy       = !gold_empty || !gate_empty;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted.
  assign active    = enable && (state == RUN) && !clear;
  assign pop       = active && !gold_empty && !gate_empty;
  assign gold_push = active && gold_valid && (!gold_full || pop);
  assign gate_push = active && gate_valid && (!gate_full || pop);
  assign gold_drop = active && gold_valid && gold_full && !pop;
  assign gate_drop = active && gate_valid && gate_full && !pop;

  assign diff     = gold_mem[gold_rp[AW-1:0]] ^ gate_mem[gate_rp[AW-1:0]];
  assign mismatch = pop && (diff != '0);

  always_comb begin
    low_bit = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) low_bit = BW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    halted    = (state == HALT);
    if (clear) state_nxt = RUN;
    else if (state == RUN && mismatch && STOP_ON_FAIL) state_nxt = HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (gold_push) gold_mem[gold_wp[AW-1:0]] <= gold_data;
    if (gate_push) gate_mem[gate_wp[AW-1:0]] <= gate_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gold_wp <= '0;
      gold_rp <= '0;
      gate_wp <= '0;
      gate_rp <= '0;
    end else if (clear) begin
      gold_wp <= '0;
      gold_rp <= '0;
      gate_wp <= '0;
      gate_rp <= '0;
    end else begin
      if (gold_push) gold_wp <= gold_wp + PTR_ONE;
      if (gate_push) gate_wp <= gate_wp + PTR_ONE;
      if (pop) begin
        gold_rp <= gold_rp + PTR_ONE;
        gate_rp <= gate_rp + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail          <= 1'b0;
      overflow      <= 1'b0;
      compare_cnt   <= '0;
      mismatch_cnt  <= '0;
      first_bad_bit <= '0;
      first_bad_idx <= '0;
    end else if (clear) begin
      fail          <= 1'b0;
      overflow      <= 1'b0;
      compare_cnt   <= '0;
      mismatch_cnt  <= '0;
      first_bad_bit <= '0;
      first_bad_idx <= '0;
    end else begin
      if (gold_drop || gate_drop) overflow <= 1'b1;
      if (pop && compare_cnt != CNT_MAX) compare_cnt <= compare_cnt + CNT_ONE;
      if (mismatch) begin
        fail <= 1'b1;
        if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_ONE;
        if (!fail) begin
          first_bad_bit <= low_bit;
          first_bad_idx <= compare_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_text_out_miter_checker.sv
// Directed bench for aes_text_out_miter_checker: a default instance plus a
// CNT_W=4, STOP_ON_FAIL=0 instance whose gate stream always differs in bit 3.
module tb_aes_text_out_miter_checker;

  localparam logic [127:0] FLIP3  = (128'h1 << 5) | (128'h1 << 77);
  localparam logic [127:0] FLIPB3 = 128'h1 << 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic         clear = 1'b0;
  logic         gold_valid = 1'b0;
  logic [127:0] gold_data = '0;
  logic         gate_valid = 1'b0;
  logic [127:0] gate_data = '0;
  logic [127:0] gate_data2;

  logic         busy, fail, overflow, halted;
  logic [15:0]  compare_cnt, mismatch_cnt, first_bad_idx;
  logic [6:0]   first_bad_bit;

  logic         busy2, fail2, overflow2, halted2;
  logic [3:0]   compare_cnt2, mismatch_cnt2, first_bad_idx2;
  logic [6:0]   first_bad_bit2;

  int checks = 0;
  int errors = 0;

  assign gate_data2 = gate_data ^ FLIPB3;

  always #5 clk = ~clk;

  aes_text_out_miter_checker dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .gold_valid(gold_valid), .gold_data(gold_data),
    .gate_valid(gate_valid), .gate_data(gate_data),
    .busy(busy), .fail(fail), .overflow(overflow), .halted(halted),
    .compare_cnt(compare_cnt), .mismatch_cnt(mismatch_cnt),
    .first_bad_bit(first_bad_bit), .first_bad_idx(first_bad_idx)
  );

  aes_text_out_miter_checker #(.CNT_W(4), .STOP_ON_FAIL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .gold_valid(gold_valid), .gold_data(gold_data),
    .gate_valid(gate_valid), .gate_data(gate_data2),
    .busy(busy2), .fail(fail2), .overflow(overflow2), .halted(halted2),
    .compare_cnt(compare_cnt2), .mismatch_cnt(mismatch_cnt2),
    .first_bad_bit(first_bad_bit2), .first_bad_idx(first_bad_idx2)
  );

  function automatic logic [127:0] word(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle with the given valids/data; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic gv, input logic [127:0] gd, input logic tv, input logic [127:0] td);
    gold_valid = gv;
    gold_data  = gd;
    gate_valid = tv;
    gate_data  = td;
    @(posedge clk);
    #1;
    gold_valid = 1'b0;
    gate_valid = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    applyStimulus(1'b1, word(99), 1'b1, word(99));
    clear = 1'b0;
  endtask

  initial begin
    #12;
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_cnt", 128'(compare_cnt), 128'(0));
    checkOutput("rst_halted", 128'(halted), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: aligned equal words
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, word(i), 1'b1, word(i));
      if (i == 0) checkOutput("t1_busy_mid", 128'(busy), 128'(1));
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t1_cnt", 128'(compare_cnt), 128'(3));
    checkOutput("t1_fail", 128'(fail), 128'(0));
    checkOutput("t1_busy", 128'(busy), 128'(0));

    // Clear with valids high: clear wins, nothing pushed
    doClear();
    checkOutput("clr_cnt", 128'(compare_cnt), 128'(0));
    checkOutput("clr_busy", 128'(busy), 128'(0));

    // Test 2: gate three cycles behind gold
    for (int c = 0; c < 7; c++) begin
      applyStimulus(c < 4, word(10 + c), c >= 3, word(10 + c - 3));
      if (c == 3) checkOutput("t2_busy_full", 128'(busy), 128'(1));
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t2_cnt", 128'(compare_cnt), 128'(4));
    checkOutput("t2_fail", 128'(fail), 128'(0));
    checkOutput("t2_ovf", 128'(overflow), 128'(0));
    checkOutput("t2_busy", 128'(busy), 128'(0));

    // Test 3: second pair differs in bits 5 and 77
    doClear();
    applyStimulus(1'b1, word(20), 1'b1, word(20));
    applyStimulus(1'b1, word(21), 1'b1, word(21) ^ FLIP3);
    applyStimulus(1'b1, word(22), 1'b1, word(22));
    checkOutput("t3_fail", 128'(fail), 128'(1));
    checkOutput("t3_halted", 128'(halted), 128'(1));
    checkOutput("t3_bit", 128'(first_bad_bit), 128'(5));
    checkOutput("t3_idx", 128'(first_bad_idx), 128'(1));
    checkOutput("t3_mm", 128'(mismatch_cnt), 128'(1));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, word(30 + i), 1'b1, word(40 + i));
    checkOutput("t3_cnt_frozen", 128'(compare_cnt), 128'(2));
    checkOutput("t3_mm_frozen", 128'(mismatch_cnt), 128'(1));
    checkOutput("t3_ovf", 128'(overflow), 128'(0));
    checkOutput("t3_still_halted", 128'(halted), 128'(1));

    // Test 4: gold overruns DEPTH, gate catches up later
    doClear();
    checkOutput("t4_halt_cleared", 128'(halted), 128'(0));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, word(40 + i), 1'b0, '0);
      if (i == 3) checkOutput("t4_ovf_4th", 128'(overflow), 128'(0));
    end
    checkOutput("t4_ovf_5th", 128'(overflow), 128'(1));
    checkOutput("t4_busy_residue", 128'(busy), 128'(1));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, word(40 + i));
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t4_cnt", 128'(compare_cnt), 128'(4));
    checkOutput("t4_fail", 128'(fail), 128'(0));
    checkOutput("t4_busy", 128'(busy), 128'(0));

    // Test 5: 20 pairs; dut2 mismatches every pair and saturates at 15
    doClear();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, word(50 + i), 1'b1, word(50 + i));
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t5_cnt_main", 128'(compare_cnt), 128'(20));
    checkOutput("t5_cnt2", 128'(compare_cnt2), 128'(15));
    checkOutput("t5_mm2", 128'(mismatch_cnt2), 128'(15));
    checkOutput("t5_idx2", 128'(first_bad_idx2), 128'(0));
    checkOutput("t5_bit2", 128'(first_bad_bit2), 128'(3));
    checkOutput("t5_fail2", 128'(fail2), 128'(1));
    checkOutput("t5_halted2", 128'(halted2), 128'(0));

    // enable=0 drops inputs silently
    doClear();
    enable = 1'b0;
    applyStimulus(1'b1, word(1), 1'b1, word(1));
    applyStimulus(1'b1, word(2), 1'b0, '0);
    enable = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("en0_cnt", 128'(compare_cnt), 128'(0));
    checkOutput("en0_busy", 128'(busy), 128'(0));

    // Test 6: async reset with words queued
    applyStimulus(1'b1, word(70), 1'b1, word(70));
    applyStimulus(1'b1, word(71), 1'b0, '0);
    applyStimulus(1'b1, word(72), 1'b0, '0);
    checkOutput("t6_pre_cnt", 128'(compare_cnt), 128'(1));
    checkOutput("t6_pre_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_cnt", 128'(compare_cnt), 128'(0));
    checkOutput("t6_rst_busy", 128'(busy), 128'(0));
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, word(80), 1'b1, word(80));
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t6_cnt", 128'(compare_cnt), 128'(1));
    checkOutput("t6_fail", 128'(fail), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
